// File: rtl/network_switch_pkg.sv
// rtl/network_switch_pkg.sv - flit-type encoding and helpers shared by the NoC switch, datapath and NI
package network_switch_pkg;

  typedef enum logic [1:0] {
    FLIT_HEADER      = 2'd0,
    FLIT_BODY        = 2'd1,
    FLIT_TAIL        = 2'd2,
    FLIT_HEADER_TAIL = 2'd3
  } flit_type_e;

  function automatic logic is_header(input logic [1:0] flit_type);
    return (flit_type == FLIT_HEADER) || (flit_type == FLIT_HEADER_TAIL);
  endfunction

  function automatic logic is_tail(input logic [1:0] flit_type);
    return (flit_type == FLIT_TAIL) || (flit_type == FLIT_HEADER_TAIL);
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - combinational round-robin pick: first request at or above start, wrapping
module round_robin_arbiter #(
  parameter int N    = 5,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/network_switch_output_arbiter.sv
// rtl/network_switch_output_arbiter.sv - per-output-port allocator with wormhole VC locking and round-robin fairness
module network_switch_output_arbiter
  import network_switch_pkg::*;
#(
  parameter int NumberOfInputPorts             = 5,
  parameter int NetworkNumberOfVirtualChannels = 2,
  parameter int NetworkFlitTypeWidth           = 2,
  parameter int NetworkVirtualChannelIdWidth   = 1
) (
  input  logic clk_network_i,
  input  logic rst_network_ni,
  input  logic [NumberOfInputPorts*NetworkNumberOfVirtualChannels-1:0]                      request_i,
  input  logic [NumberOfInputPorts*NetworkNumberOfVirtualChannels*NetworkFlitTypeWidth-1:0] request_flit_type_i,
  input  logic [NetworkNumberOfVirtualChannels-1:0]                                         go_i,
  output logic [NumberOfInputPorts*NetworkNumberOfVirtualChannels-1:0]                      grant_o,
  output logic                                                                              valid_o,
  output logic [NetworkVirtualChannelIdWidth-1:0]                                           vc_o,
  output logic [NetworkNumberOfVirtualChannels-1:0]                                         locked_o,
  output logic                                                                              protocol_error_o
);

  localparam int P   = NumberOfInputPorts;
  localparam int V   = NetworkNumberOfVirtualChannels;
  localparam int FTW = NetworkFlitTypeWidth;
  localparam int VCW = NetworkVirtualChannelIdWidth;
  localparam int PW  = (P > 1) ? $clog2(P) : 1;

  logic [V-1:0]   lock_q, lock_d;
  logic [PW-1:0]  owner_q [V];
  logic [PW-1:0]  owner_d [V];
  logic [PW-1:0]  port_ptr_q [V];
  logic [PW-1:0]  port_ptr_d [V];
  logic [VCW-1:0] vc_ptr_q, vc_ptr_d;

  logic [FTW-1:0] flit_type [P][V];
  logic [P-1:0]   hdr_req [V];
  logic [P-1:0]   port_gnt [V];
  logic [PW-1:0]  port_idx [V];
  logic [V-1:0]   port_found;
  logic [V-1:0]   owner_cont;
  logic [V-1:0]   vc_cand;
  logic [V-1:0]   vc_gnt;
  logic [VCW-1:0] vc_idx;
  logic           vc_found;
  logic           illegal;
  logic [P*V-1:0] grant_vec;
  logic [PW-1:0]  sel_port;
  logic [1:0]     sel_type;

  // Headers compete only on unlocked VCs; a locked VC carries just its owner's body/tail flits.
  always_comb begin : classify
    illegal = 1'b0;
    for (int v = 0; v < V; v++) begin
      hdr_req[v]    = '0;
      owner_cont[v] = 1'b0;
      for (int p = 0; p < P; p++) begin
        flit_type[p][v] = request_flit_type_i[(p*V+v)*FTW +: FTW];
        if (request_i[p*V+v]) begin
          if (is_header(2'(flit_type[p][v]))) begin
            if (!lock_q[v])                     hdr_req[v][p] = 1'b1;
            else if (int'(owner_q[v]) == p)     illegal       = 1'b1;
          end else begin
            if (!lock_q[v])                     illegal       = 1'b1;
            else if (int'(owner_q[v]) == p)     owner_cont[v] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar v = 0; v < V; v++) begin : g_port_arb
    round_robin_arbiter #(.N(P), .IdxW(PW)) u_port_arb (
      .req_i   (hdr_req[v]),
      .start_i (port_ptr_q[v]),
      .gnt_o   (port_gnt[v]),
      .idx_o   (port_idx[v]),
      .valid_o (port_found[v])
    );
  end

  always_comb begin : vc_candidates
    vc_cand = '0;
    for (int v = 0; v < V; v++) begin
      vc_cand[v] = go_i[v] & (lock_q[v] ? owner_cont[v] : port_found[v]);
    end
  end

  round_robin_arbiter #(.N(V), .IdxW(VCW)) u_vc_arb (
    .req_i   (vc_cand),
    .start_i (vc_ptr_q),
    .gnt_o   (vc_gnt),
    .idx_o   (vc_idx),
    .valid_o (vc_found)
  );

  always_comb begin : grant_select
    grant_vec = '0;
    for (int v = 0; v < V; v++) begin
      for (int p = 0; p < P; p++) begin
        if (vc_gnt[v] && (lock_q[v] ? (int'(owner_q[v]) == p) : port_gnt[v][p])) begin
          grant_vec[p*V+v] = 1'b1;
        end
      end
    end
    sel_port = lock_q[vc_idx] ? owner_q[vc_idx] : port_idx[vc_idx];
    sel_type = 2'(flit_type[sel_port][vc_idx]);
  end

  always_comb begin : next_state
    lock_d     = lock_q;
    owner_d    = owner_q;
    port_ptr_d = port_ptr_q;
    vc_ptr_d   = vc_ptr_q;
    if (vc_found) begin
      vc_ptr_d = VCW'((int'(vc_idx) + 1) % V);
      if (is_header(sel_type)) port_ptr_d[vc_idx] = PW'((int'(sel_port) + 1) % P);
      if (sel_type == FLIT_HEADER) begin
        lock_d[vc_idx]  = 1'b1;
        owner_d[vc_idx] = sel_port;
      end else if (is_tail(sel_type)) begin
        lock_d[vc_idx]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
    if (!rst_network_ni) begin
      lock_q   <= '0;
      vc_ptr_q <= '0;
      for (int v = 0; v < V; v++) begin
        owner_q[v]    <= '0;
        port_ptr_q[v] <= '0;
      end
    end else begin
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      port_ptr_q <= port_ptr_d;
      vc_ptr_q   <= vc_ptr_d;
    end
  end

  // Decision outputs are combinational, so they are gated directly by the reset pin.
  assign grant_o          = rst_network_ni ? grant_vec : '0;
  assign valid_o          = rst_network_ni & vc_found;
  assign vc_o             = (rst_network_ni && vc_found) ? vc_idx : '0;
  assign locked_o         = lock_q;
  assign protocol_error_o = rst_network_ni & illegal;

endmodule

// File: tb/tb_network_switch_output_arbiter.sv
// tb/tb_network_switch_output_arbiter.sv - scoreboard bench for the output-port allocator
module tb_network_switch_output_arbiter;

  localparam int F_H  = 0;
  localparam int F_B  = 1;
  localparam int F_T  = 2;
  localparam int F_HT = 3;

  typedef struct packed {
    logic [9:0] grant;
    logic       valid;
    logic       vc;
    logic [1:0] locked;
    logic       err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  request = '0;
  logic [19:0] ftype = '0;
  logic [1:0]  go = 2'b11;
  logic [9:0]  grant;
  logic        valid;
  logic [0:0]  vc;
  logic [1:0]  locked;
  logic        perr;
  obs_t        obs;
  obs_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  network_switch_output_arbiter dut (
    .clk_network_i       (clk),
    .rst_network_ni      (rst_n),
    .request_i           (request),
    .request_flit_type_i (ftype),
    .go_i                (go),
    .grant_o             (grant),
    .valid_o             (valid),
    .vc_o                (vc),
    .locked_o            (locked),
    .protocol_error_o    (perr)
  );

  always #5 clk = ~clk;

  assign obs = {grant, valid, vc, locked, perr};

  function automatic obs_t expect_of(int bit_idx, int lk, logic err);
    obs_t e;
    e.grant  = '0;
    e.valid  = 1'b0;
    e.vc     = 1'b0;
    if (bit_idx >= 0) begin
      e.grant[bit_idx] = 1'b1;
      e.valid          = 1'b1;
      e.vc             = 1'(bit_idx % 2);
    end
    e.locked = 2'(lk);
    e.err    = err;
    return e;
  endfunction

  task automatic clear_req();
    request = '0;
    ftype   = '0;
  endtask

  task automatic add_req(int p, int v, int t);
    request[p*2+v]        = 1'b1;
    ftype[(p*2+v)*2 +: 2] = 2'(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_req();
    go = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    clear_req();
    go = 2'b11;
    add_req(0, 0, F_H);
    exp_q.push_back(expect_of(-1, 0, 1'b0));
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    exp_q.push_back(expect_of(-1, 0, 1'b0));
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_edge: got %h expected %h", obs, e); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(expect_of(0, 0, 1'b0));
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_release: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    clear_req();
    exp_q.push_back(expect_of(-1, 1, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_first_lock: got %h expected %h", obs, e); end
  endtask

  task automatic test_single_packet();
    int   ty[5] = '{F_H, F_B, F_B, F_T, -1};
    int   lk[5] = '{0, 1, 1, 1, 0};
    obs_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      clear_req();
      if (ty[i] >= 0) add_req(1, 0, ty[i]);
      exp_q.push_back(expect_of((ty[i] >= 0) ? 2 : -1, lk[i], 1'b0));
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL single_packet step %0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_port_fairness();
    int   eb[6] = '{0, 4, 8, 0, 4, 8};
    obs_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      clear_req();
      add_req(0, 0, F_HT);
      add_req(2, 0, F_HT);
      add_req(4, 0, F_HT);
      exp_q.push_back(expect_of(eb[i], 0, 1'b0));
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL port_fairness step %0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_wormhole_hold();
    int   t3[5] = '{F_H, F_B, F_T, -1, -1};
    int   t0[5] = '{-1, F_H, F_H, F_H, -1};
    int   eb[5] = '{7, 7, 7, 1, -1};
    int   lk[5] = '{0, 2, 2, 0, 2};
    obs_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      clear_req();
      if (t3[i] >= 0) add_req(3, 1, t3[i]);
      if (t0[i] >= 0) add_req(0, 1, t0[i]);
      exp_q.push_back(expect_of(eb[i], lk[i], 1'b0));
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL wormhole_hold step %0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_vc_interleave_go();
    int   ta[9] = '{F_H, F_B, F_B, F_B, F_T, -1, -1, -1, -1};
    int   tb[9] = '{F_H, F_H, F_B, F_B, F_B, F_B, F_B, F_T, -1};
    int   gv[9] = '{3, 3, 3, 1, 1, 1, 3, 3, 3};
    int   eb[9] = '{2, 5, 2, 2, 2, -1, 5, 5, -1};
    int   lk[9] = '{0, 1, 3, 3, 3, 2, 2, 2, 0};
    obs_t e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      clear_req();
      if (ta[i] >= 0) add_req(1, 0, ta[i]);
      if (tb[i] >= 0) add_req(2, 1, tb[i]);
      go = 2'(gv[i]);
      exp_q.push_back(expect_of(eb[i], lk[i], 1'b0));
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL vc_interleave step %0d: got %h expected %h", i, obs, e); end
    end
    go = 2'b11;
  endtask

  task automatic test_protocol_error();
    int   eb[4] = '{-1, -1, 3, 0};
    int   lk[4] = '{0, 0, 0, 2};
    logic er[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    obs_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      clear_req();
      case (i)
        0: add_req(4, 0, F_B);
        2: add_req(1, 1, F_H);
        3: begin add_req(1, 1, F_H); add_req(0, 0, F_H); end
        default: ;
      endcase
      exp_q.push_back(expect_of(eb[i], lk[i], er[i]));
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL protocol_error step %0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    do_reset();
    @(posedge clk); #1;
    clear_req(); add_req(2, 0, F_H);
    exp_q.push_back(expect_of(4, 0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL async_header: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    clear_req(); add_req(2, 0, F_B);
    exp_q.push_back(expect_of(4, 1, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL async_body: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    clear_req(); add_req(2, 0, F_T);
    #2 rst_n = 1'b0;
    exp_q.push_back(expect_of(-1, 0, 1'b0));
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL async_assert: got %h expected %h", obs, e); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_q.push_back(expect_of(-1, 0, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL stale_tail: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    clear_req();
    exp_q.push_back(expect_of(-1, 0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL after_stale: got %h expected %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_port_fairness();
    test_wormhole_hold();
    test_vc_interleave_go();
    test_protocol_error();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
